// File: rtl/seg_shift_rx.sv
// seg_shift_rx: serial-to-parallel receiver for the LSB-first 7-segment shift link
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   sen       shift enable, one bit per cycle while high
//   sin       serial data, LSB first, idles high
//   data      last complete frame, bit 0 = first bit received
//   valid     one-cycle pulse when data is updated
//   busy      registered, high while in SHIFT
//   err_short sticky, last frame ended early
//   err_long  sticky, a 0 was seen after a complete frame
module seg_shift_rx #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sen,
   input  logic             sin,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             busy,
   output logic             err_short,
   output logic             err_long
);
   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
   state_t           state, next;
   logic [WIDTH-1:0] sr, sr_nxt;
   logic [CNT_W-1:0] cnt;
   logic             last;
   // The oldest bit falls off the bottom; after WIDTH samples bit 0 is the first one.
   assign sr_nxt = {sin, sr[WIDTH-1:1]};
   assign last   = (cnt == CNT_W'(WIDTH - 1));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= next;
   always_comb begin
      next = state;
      unique case (state)
         IDLE:    next = sen ? SHIFT : IDLE;
         SHIFT:   next = !sen ? IDLE : (last ? HOLD : SHIFT);
         HOLD:    next = sen ? HOLD : IDLE;
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sr        <= '0;
         cnt       <= '0;
         data      <= '0;
         valid     <= 1'b0;
         busy      <= 1'b0;
         err_short <= 1'b0;
         err_long  <= 1'b0;
      end else begin
         valid <= 1'b0;
         busy  <= (next == SHIFT);
         unique case (state)
            IDLE:
               if (sen) begin
                  sr        <= {sin, {(WIDTH-1){1'b0}}};
                  cnt       <= CNT_W'(1);
                  err_short <= 1'b0;
                  err_long  <= 1'b0;
               end else cnt <= '0;
            SHIFT:
               if (sen) begin
                  sr  <= sr_nxt;
                  cnt <= cnt + 1'b1;
                  // WIDTH-th sample: publish on this same edge so valid follows the last bit.
                  if (last) begin
                     data  <= sr_nxt;
                     valid <= 1'b1;
                  end
               end else err_short <= 1'b1;
            HOLD:
               if (sen && !sin) err_long <= 1'b1;
            default: ;
         endcase
      end
endmodule

// File: tb/tb_seg_shift_rx.sv
// tb_seg_shift_rx: directed self-checking bench for seg_shift_rx
module tb_seg_shift_rx;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sen = 1'b0;
   logic        sin = 1'b1;
   logic [63:0] data;
   logic        valid, busy, err_short, err_long;
   int          total = 0, fails = 0;
   int          vcnt = 0, cyc_n = 0, vlast = 0, vprev = 0, v0 = 0;

   seg_shift_rx dut (
      .clk(clk), .rst_n(rst_n), .sen(sen), .sin(sin), .data(data),
      .valid(valid), .busy(busy), .err_short(err_short), .err_long(err_long)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n++;
   always @(negedge clk)
      if (valid) begin
         vcnt++;
         vprev = vlast;
         vlast = cyc_n;
      end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic e, input logic b);
      sen = e;
      sin = b;
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [63:0] w);
      for (int i = 0; i < 64; i++) cyc(1'b1, w[i]);
   endtask

   localparam logic [63:0] FA = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] FC = 64'hDEAD_BEEF_CAFE_F00D;
   localparam logic [63:0] FR = 64'hFFFF_0000_FFFF_0000;
   localparam logic [63:0] F5 = 64'h5555_5555_5555_5555;
   localparam logic [63:0] FX = 64'hAAAA_AAAA_AAAA_AAAA;

   initial begin
      logic [63:0] fa;
      fa = FA;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data", data, 64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_errs", 64'({err_short, err_long}), 64'd0);
      rst_n = 1'b1;
      cyc(1'b0, 1'b1);

      v0 = vcnt;
      cyc(1'b1, fa[0]);
      chk("full_busy", 64'(busy), 64'd1);
      for (int i = 1; i < 64; i++) cyc(1'b1, fa[i]);
      chk("full_valid", 64'(valid), 64'd1);
      chk("full_data", data, FA);
      chk("full_busy_end", 64'(busy), 64'd0);
      chk("full_errs", 64'({err_short, err_long}), 64'd0);
      cyc(1'b0, 1'b1);
      chk("full_valid_off", 64'(valid), 64'd0);
      chk("full_pulses", 64'(vcnt - v0), 64'd1);

      v0 = vcnt;
      for (int i = 0; i < 10; i++) cyc(1'b1, i[0]);
      cyc(1'b0, 1'b1);
      chk("short_err", 64'(err_short), 64'd1);
      chk("short_valid", 64'(valid), 64'd0);
      chk("short_data", data, FA);
      chk("short_busy", 64'(busy), 64'd0);
      cyc(1'b0, 1'b1);
      chk("short_pulses", 64'(vcnt - v0), 64'd0);

      v0 = vcnt;
      cyc(1'b1, FC[0]);
      chk("short_cleared", 64'(err_short), 64'd0);
      for (int i = 1; i < 64; i++) cyc(1'b1, FC[i]);
      chk("fill_data", data, FC);
      for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1);
      chk("fill_valid_off", 64'(valid), 64'd0);
      chk("fill_errlong", 64'(err_long), 64'd0);
      cyc(1'b0, 1'b1);
      chk("fill_pulses", 64'(vcnt - v0), 64'd1);

      v0 = vcnt;
      frame(FA);
      for (int i = 0; i < 20; i++) cyc(1'b1, i != 5);
      chk("long_err", 64'(err_long), 64'd1);
      chk("long_data", data, FA);
      cyc(1'b0, 1'b1);
      chk("long_sticky", 64'(err_long), 64'd1);
      chk("long_pulses", 64'(vcnt - v0), 64'd1);

      v0 = vcnt;
      for (int i = 0; i < 30; i++) cyc(1'b1, FC[i]);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_data", data, 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_errlong", 64'(err_long), 64'd0);
      sen = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1'b0, 1'b1);
      chk("arst_pulses", 64'(vcnt - v0), 64'd0);
      frame(FR);
      chk("arst_frame_valid", 64'(valid), 64'd1);
      chk("arst_frame_data", data, FR);
      cyc(1'b0, 1'b1);

      v0 = vcnt;
      frame(FX);
      chk("b2b_data1", data, FX);
      cyc(1'b0, 1'b1);
      chk("b2b_gap_valid", 64'(valid), 64'd0);
      frame(F5);
      chk("b2b_valid2", 64'(valid), 64'd1);
      chk("b2b_data2", data, F5);
      cyc(1'b0, 1'b1);
      chk("b2b_pulses", 64'(vcnt - v0), 64'd2);
      chk("b2b_spacing", 64'(vlast - vprev), 64'd65);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule

// File: doc/seg_shift_rx.md
Name: seg_shift_rx

Overview:
- Serial-to-parallel receiver for the 7-segment serial display link: the receiving end of the 64-bit, LSB-first shift stream the display driver emits.
- Reassembles one frame into a parallel word, flags short and overlong frames, and presents the word with a one-cycle valid pulse.
- Used as the display-board shift-chain model in simulation and as the on-chip loopback checker.

Parameters:
- WIDTH, 64, frame length in bits (≥2).
- CNT_W, 7, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sen  input  1  shift enable; high = frame in progress, one bit per cycle.
- sin  input  1  serial data, LSB first; line idles high.
- data  output  WIDTH  last complete frame, bit 0 = first bit received.
- valid  output  1  one-cycle pulse, data updated this cycle.
- busy  output  1  high while in SHIFT state.
- err_short  output  1  sticky: last frame ended with fewer than WIDTH bits.
- err_long  output  1  sticky: a 0 was sampled after WIDTH bits in the current frame.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, shift register=0, cnt=0, data=0, valid=0, busy=0, err_short=0, err_long=0.
- States: IDLE, SHIFT, HOLD.
- Frame start:
  - Any cycle with sen=1 while in IDLE samples sin as bit 0 and moves to SHIFT.
  - The same cycle clears err_short and err_long, and sets cnt=1.
- SHIFT, sen=1:
  - Shift register shifts right, sin enters at MSB; after WIDTH samples, bit 0 holds the first bit received.
  - cnt increments.
  - On the WIDTH-th sample, the next edge loads data with the assembled word, pulses valid for exactly one cycle, and moves to HOLD.
  - Latency: valid is high in the cycle after the edge that samples the last bit.
- SHIFT, sen=0 with cnt<WIDTH:
  - Frame is discarded; data keeps its old value.
  - err_short set, state returns to IDLE, no valid pulse.
- HOLD, sen=1 (trailing fill):
  - Each sin=1 is ignored.
  - Any sin=0 sets err_long; data is not modified.
  - cnt saturates at WIDTH.
- HOLD, sen=0: state returns to IDLE; no error.
- busy equals (state==SHIFT), registered.
- Back-to-back frames:
  - sen must be low for at least one cycle between frames to re-enter IDLE.
  - A frame starting the cycle after IDLE is entered is accepted with no lost bits.
- Sticky errors persist until the next frame start or reset.
- valid and err_short never assert in the same cycle.
- Reset mid-frame: all state is cleared immediately, the partial word is dropped, and no valid pulse is produced.
- Width rules: cnt is CNT_W bits, compared against WIDTH with no wrap; the shift register is exactly WIDTH bits.

Test Plan:
- Full frame: sen=1 for 64 cycles carrying 64'h0123_4567_89AB_CDEF LSB-first, then sen=0 → data=64'h0123_4567_89AB_CDEF, valid high exactly 1 cycle (cycle 65), err_short=0, err_long=0.
- Short frame: sen=1 for 10 cycles then low → err_short=1, valid never pulses, data unchanged from the prior frame; next good frame clears err_short.
- Overlong fill: 64-bit frame followed by 20 extra cycles of sin=1 with sen=1 → single valid pulse, err_long=0. Repeat with one sin=0 at extra cycle 5 → err_long=1, data still equals the 64-bit frame.
- Reset mid-frame: assert rst_n=0 at bit 30 → all outputs 0 asynchronously. A following full frame of 64'hFFFF_0000_FFFF_0000 is received correctly.
- Back-to-back: two frames (64'hAAAA…, 64'h5555…) separated by a single sen=0 cycle → two valid pulses 65 cycles apart, data matching each frame.
